// File: rtl/req_pending_bank.sv
// Per-requester pending-item counter bank feeding a round-robin arbiter.
// Each channel holds a saturating count of queued items. A non-zero count raises
// that channel's level request. A valid one-hot grant retires one item from the granted channel.
module req_pending_bank #(
  parameter int unsigned WID  = 16,
  parameter int unsigned CNTW = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WID-1:0]                        push_valid,
  output logic [WID-1:0]                        push_ready,
  output logic [WID-1:0]                        requests,
  input  logic [WID-1:0]                        grants,
  output logic                                  served_valid,
  output logic [((WID > 1) ? $clog2(WID) : 1)-1:0] served_id,
  output logic [CNTW+((WID > 1) ? $clog2(WID) : 1)-1:0] total_pending,
  output logic                                  err_spurious,
  output logic                                  err_multi,
  input  logic                                  clr_err
);

  localparam int unsigned WADDR = (WID > 1) ? $clog2(WID) : 1;
  localparam int unsigned TOTW  = CNTW + WADDR;
  localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

  logic [CNTW-1:0]  count_q [WID];
  logic [CNTW-1:0]  count_d [WID];
  logic             served_valid_q;
  logic [WADDR-1:0] served_id_q;
  logic             err_spurious_q;
  logic             err_multi_q;

  logic             grant_multi;
  logic             grant_onehot;
  logic [WADDR-1:0] grant_idx;
  logic             grant_valid;
  logic             grant_spurious;
  logic [WID-1:0]   grant_dec;

  // Derived outputs depend only on registered counts, keeping the arbiter loop acyclic.
  always_comb begin
    total_pending = '0;
    for (int i = 0; i < WID; i++) begin
      requests[i]   = (count_q[i] != '0);
      push_ready[i] = (count_q[i] != CntMax);
      total_pending = total_pending + TOTW'(count_q[i]);
    end
  end

  // Classify the grant vector: idle, multi-hot, valid one-hot or spurious one-hot.
  always_comb begin
    grant_multi  = |(grants & (grants - 1'b1));
    grant_onehot = (grants != '0) && !grant_multi;
    grant_idx    = '0;
    for (int i = 0; i < WID; i++) begin
      if (grants[i]) grant_idx = WADDR'(i);
    end
    grant_valid    = grant_onehot && (count_q[grant_idx] != '0);
    grant_spurious = grant_onehot && (count_q[grant_idx] == '0);
    grant_dec      = grant_valid ? grants : '0;
  end

  // Per-channel next count; a push and a retire on the same channel cancel out,
  // so a full channel being served while its source still offers stays full.
  always_comb begin
    for (int i = 0; i < WID; i++) begin
      count_d[i] = count_q[i];
      if (grant_dec[i] && push_valid[i]) begin
        count_d[i] = count_q[i];
      end else if (grant_dec[i]) begin
        count_d[i] = count_q[i] - CNTW'(1);
      end else if (push_valid[i] && push_ready[i]) begin
        count_d[i] = count_q[i] + CNTW'(1);
      end
    end
  end

  // State update: counts, served report and sticky error flags (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WID; i++) count_q[i] <= '0;
      served_valid_q <= 1'b0;
      served_id_q    <= '0;
      err_spurious_q <= 1'b0;
      err_multi_q    <= 1'b0;
    end else begin
      for (int i = 0; i < WID; i++) count_q[i] <= count_d[i];
      served_valid_q <= grant_valid;
      if (grant_valid) served_id_q <= grant_idx;
      err_spurious_q <= grant_spurious || (err_spurious_q && !clr_err);
      err_multi_q    <= grant_multi || (err_multi_q && !clr_err);
    end
  end

  assign served_valid = served_valid_q;
  assign served_id    = served_id_q;
  assign err_spurious = err_spurious_q;
  assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_req_pending_bank.sv
// Scoreboard bench for req_pending_bank: stimulus pushes expected post-edge state,
// an independent monitor pops and compares after every rising edge.
module tb_req_pending_bank;

  localparam int WID  = 16;
  localparam int CNTW = 4;
  localparam int MAX  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] push_valid;
  logic [15:0] push_ready;
  logic [15:0] requests;
  logic [15:0] grants;
  logic        served_valid;
  logic [3:0]  served_id;
  logic [7:0]  total_pending;
  logic        err_spurious;
  logic        err_multi;
  logic        clr_err;

  req_pending_bank #(.WID(WID), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .requests     (requests),
    .grants       (grants),
    .served_valid (served_valid),
    .served_id    (served_id),
    .total_pending(total_pending),
    .err_spurious (err_spurious),
    .err_multi    (err_multi),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int req;
    int rdy;
    int tot;
    int sv;
    int sid;
    int es;
    int em;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain integer counts per channel.
  int cnt[WID];
  int m_sv, m_sid, m_es, m_em;
  int rr_last = WID - 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus and record the state expected after the next edge.
  task automatic step(input logic r, input logic [15:0] pv, input logic [15:0] g,
                      input logic c);
    exp_t e;
    int   n;
    int   gi;
    bit   gv;
    @(negedge clk);
    rst = r; push_valid = pv; grants = g; clr_err = c;
    if (r) begin
      for (int i = 0; i < WID; i++) cnt[i] = 0;
      m_sv = 0; m_sid = 0; m_es = 0; m_em = 0;
    end else begin
      n  = $countones(g);
      gi = -1;
      if (n == 1) for (int i = 0; i < WID; i++) if (g[i]) gi = i;
      gv = (gi >= 0) && (cnt[gi] > 0);
      m_em = ((n > 1) || (m_em != 0 && !c)) ? 1 : 0;
      m_es = (((gi >= 0) && (cnt[gi] == 0)) || (m_es != 0 && !c)) ? 1 : 0;
      for (int i = 0; i < WID; i++) begin
        if (gv && gi == i && pv[i]) begin
          // retire and new item offset each other
        end else begin
          if (pv[i] && cnt[i] < MAX) cnt[i] = cnt[i] + 1;
          if (gv && gi == i) cnt[i] = cnt[i] - 1;
        end
      end
      m_sv = gv ? 1 : 0;
      if (gv) m_sid = gi;
    end
    e.req = 0; e.rdy = 0; e.tot = 0;
    for (int i = 0; i < WID; i++) begin
      if (cnt[i] != 0)   e.req += (1 << i);
      if (cnt[i] != MAX) e.rdy += (1 << i);
      e.tot += cnt[i];
    end
    e.sv = m_sv; e.sid = m_sid; e.es = m_es; e.em = m_em;
    exp_q.push_back(e);
  endtask

  // Round-robin pick from the model's pending counts, as the real arbiter would.
  function automatic logic [15:0] rr_pick();
    logic [15:0] g;
    int idx;
    g = '0;
    for (int k = 1; k <= WID; k++) begin
      idx = (rr_last + k) % WID;
      if (cnt[idx] > 0) begin
        g[idx]  = 1'b1;
        rr_last = idx;
        break;
      end
    end
    return g;
  endfunction

  // Monitor: compare DUT outputs after each edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("requests",      int'(requests),      e.req);
        chk("push_ready",    int'(push_ready),    e.rdy);
        chk("total_pending", int'(total_pending), e.tot);
        chk("served_valid",  int'(served_valid),  e.sv);
        chk("served_id",     int'(served_id),     e.sid);
        chk("err_spurious",  int'(err_spurious),  e.es);
        chk("err_multi",     int'(err_multi),     e.em);
      end
    end
  end

  initial begin
    logic [15:0] pv, g;
    int          sel;
    rst = 1'b1; push_valid = '0; grants = '0; clr_err = 1'b0;
    repeat (2) step(1'b1, 16'h0, 16'h0, 1'b0);

    // Three pushes to channel 3.
    repeat (3) step(1'b0, 16'h0008, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);

    // Fill channel 0 past its limit.
    step(1'b1, 16'h0, 16'h0, 1'b0);
    repeat (16) step(1'b0, 16'h0001, 16'h0, 1'b0);

    // Push and grant on channel 5 in the same cycle.
    step(1'b1, 16'h0, 16'h0, 1'b0);
    repeat (2) step(1'b0, 16'h0020, 16'h0, 1'b0);
    step(1'b0, 16'h0020, 16'h0020, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);

    // Spurious grant, clear, then clear colliding with a new spurious grant.
    step(1'b1, 16'h0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0080, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 16'h0080, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0);

    // Multi-hot grant is ignored.
    step(1'b1, 16'h0, 16'h0, 1'b0);
    step(1'b0, 16'h0003, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0003, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);

    // Arbiter-driven service of channels 2 and 9.
    step(1'b1, 16'h0, 16'h0, 1'b0);
    rr_last = WID - 1;
    step(1'b0, 16'h0204, 16'h0, 1'b0);
    repeat (3) step(1'b0, 16'h0, rr_pick(), 1'b0);

    // Reset with items pending and a grant in flight.
    step(1'b1, 16'h0, 16'h0, 1'b0);
    repeat (6) step(1'b0, 16'h0010, 16'h0, 1'b0);
    step(1'b1, 16'h0, 16'h0010, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      pv  = 16'($urandom & $urandom);
      sel = $urandom_range(0, 99);
      if (sel < 60)      g = rr_pick();
      else if (sel < 80) g = 16'(1 << $urandom_range(0, WID - 1));
      else if (sel < 90) g = 16'($urandom);
      else               g = '0;
      step(($urandom_range(0, 199) == 0), pv, g, ($urandom_range(0, 19) == 0));
    end
    step(1'b0, 16'h0, 16'h0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
